// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the five-stage pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    localparam logic [REG_W-1:0] REG_X0  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ALU operand source selects driven to the execute stage.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    // Control bits shadowed for one in-flight instruction.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
        logic             mem_access;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when the entry will write register r; x0 is never a real destination.
    function automatic logic writes_reg(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (r != REG_X0);
    endfunction

    // The younger producer (M) shadows an older one (W) writing the same register.
    function automatic fwd_sel_e fwd_select(input sb_entry_t m, input sb_entry_t w,
                                            input logic [REG_W-1:0] rs);
        if (writes_reg(m, rs)) return FWD_M;
        if (writes_reg(w, rs)) return FWD_W;
        return FWD_RF;
    endfunction

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side bundle of the hazard controller. The pipeline
// (master) supplies decode/execute/memory status and receives the enables.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] rs1_d;
    logic [REG_W-1:0] rs2_d;
    logic [REG_W-1:0] rd_d;
    logic             reg_write_d;
    logic             result_src_d;
    logic             mem_access_d;
    logic             pc_src_e;
    logic             mem_ready;

    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             freeze;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
    logic [CNT_W-1:0] perf_wait_cnt;

    modport master (
        output rs1_d, rs2_d, rd_d, reg_write_d, result_src_d, mem_access_d,
               pc_src_e, mem_ready,
        input  stall_f, stall_d, flush_d, flush_e, freeze, fwd_a_sel, fwd_b_sel,
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, reg_write_d, result_src_d, mem_access_d,
               pc_src_e, mem_ready,
        output stall_f, stall_d, flush_d, flush_e, freeze, fwd_a_sel, fwd_b_sel,
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W shadow of the instructions in flight, with a global
// hold (memory freeze) and bubble insertion into E.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  sb_entry_t        d_entry_i,
    input  logic [REG_W-1:0] rs1_d_i,
    input  logic [REG_W-1:0] rs2_d_i,
    output sb_entry_t        e_o,
    output sb_entry_t        m_o,
    output sb_entry_t        w_o,
    output logic [REG_W-1:0] rs1_e_o,
    output logic [REG_W-1:0] rs2_e_o
);

    sb_entry_t        e_q, e_d, m_q, m_d, w_q, w_d;
    logic [REG_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;

    // Advance one stage unless held; E takes the D instruction or a bubble.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        e_d     = e_q;
        m_d     = m_q;
        w_d     = w_q;
        rs1_e_d = rs1_e_q;
        rs2_e_d = rs2_e_q;
        if (!hold_i) begin
            w_d = m_q;
            m_d = e_q;
            if (bubble_i) begin
                // A bubble has no source operands, so it never requests forwarding.
                e_d     = SB_BUBBLE;
                rs1_e_d = REG_X0;
                rs2_e_d = REG_X0;
            end else begin
                e_d     = d_entry_i;
                rs1_e_d = rs1_d_i;
                rs2_e_d = rs2_d_i;
            end
        end
    end

    // Scoreboard registers; reset empties the pipeline view even mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= SB_BUBBLE;
            m_q     <= SB_BUBBLE;
            w_q     <= SB_BUBBLE;
            rs1_e_q <= REG_X0;
            rs2_e_q <= REG_X0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
        end
    end

    assign e_o     = e_q;
    assign m_o     = m_q;
    assign w_o     = w_q;
    assign rs1_e_o = rs1_e_q;
    assign rs2_e_o = rs2_e_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze and forwarding control for the F-D-E-M-W core.
// Optional build macro HAZARD_CTRL_PERF_EN adds saturating performance counters;
// without it the counter ports read zero and no counter flops exist.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    sb_entry_t        d_entry, sb_e, sb_m, sb_w;
    logic [REG_W-1:0] rs1_e, rs2_e;
    hz_state_e        state_q, state_d;
    logic             mem_wait, redirect, load_use, lu_act;
    logic             flush_e;

    assign d_entry = '{valid:      1'b1,
                       rd:         hz.rd_d,
                       reg_write:  hz.reg_write_d,
                       is_load:    hz.result_src_d,
                       mem_access: hz.mem_access_d};

    hazard_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (mem_wait),
        .bubble_i  (flush_e),
        .d_entry_i (d_entry),
        .rs1_d_i   (hz.rs1_d),
        .rs2_d_i   (hz.rs2_d),
        .e_o       (sb_e),
        .m_o       (sb_m),
        .w_o       (sb_w),
        .rs1_e_o   (rs1_e),
        .rs2_e_o   (rs2_e)
    );

    // Hazard classification with priority: memory freeze > redirect > load-use.
    always_comb begin
        mem_wait = sb_m.valid && sb_m.mem_access && !hz.mem_ready;
        // pc_src_e is gated by reset so every output stays low while rst_n is asserted.
        redirect = rst_n && hz.pc_src_e && !mem_wait;
        load_use = sb_e.is_load &&
                   (writes_reg(sb_e, hz.rs1_d) || writes_reg(sb_e, hz.rs2_d));
        lu_act   = load_use && !mem_wait && !redirect;
    end

    assign flush_e      = redirect || lu_act;
    assign hz.freeze    = mem_wait;
    assign hz.stall_f   = mem_wait || lu_act;
    assign hz.stall_d   = mem_wait || lu_act;
    assign hz.flush_d   = redirect;
    assign hz.flush_e   = flush_e;
    assign hz.fwd_a_sel = fwd_select(sb_m, sb_w, rs1_e);
    assign hz.fwd_b_sel = fwd_select(sb_m, sb_w, rs2_e);

    // Control state: tracks whether the pipeline is running, taking a load-use bubble or waiting on memory.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait)    state_d = MEM_WAIT;
                else if (lu_act) state_d = LU_STALL;
            end
            LU_STALL: state_d = mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT: if (!mem_wait) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    // Event counters: load-use bubbles, redirects and frozen cycles, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, lu_act);
            flush_cnt_q <= sat_inc(flush_cnt_q, redirect);
            wait_cnt_q  <= sat_inc(wait_cnt_q, mem_wait);
        end
    end

    assign hz.perf_stall_cnt = stall_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
    assign hz.perf_wait_cnt  = wait_cnt_q;
`else
    assign hz.perf_stall_cnt = '0;
    assign hz.perf_flush_cnt = '0;
    assign hz.perf_wait_cnt  = '0;
`endif

    // Shadowed fields that no control decision consults.
    logic unused_sb;
    assign unused_sb = &{1'b0, sb_e.mem_access, sb_m.is_load, sb_w.is_load, sb_w.mem_access};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. A driver issues one decode-stage
// instruction per cycle and pushes the reference model's expected outputs; a monitor
// pops and compares them. The model keeps the in-flight instructions as a list and
// applies the hazard rules directly.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       wr;
        logic       ld;
        logic       mem;
    } instr_t;

    typedef struct {
        logic [4:0]  ctl;   // stall_f, stall_d, flush_d, flush_e, freeze
        logic [3:0]  fwd;   // fwd_a_sel, fwd_b_sel
        logic [95:0] perf;  // stall, flush, wait counters
    } exp_t;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    exp_t        exp_q[$];
    instr_t      pipe[$];   // [0] = E, [1] = M, [2] = W
    int unsigned cnt_stall, cnt_flush, cnt_wait;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic instr_t mk(bit wr, bit ld, bit mem, int rd, int rs1, int rs2);
        instr_t i;
        i.valid = 1'b1;
        i.wr    = wr;
        i.ld    = ld;
        i.mem   = mem;
        i.rd    = 5'(rd);
        i.rs1   = 5'(rs1);
        i.rs2   = 5'(rs2);
        return i;
    endfunction

    function automatic instr_t alu(int rd, int rs1, int rs2); return mk(1, 0, 0, rd, rs1, rs2); endfunction
    function automatic instr_t lw(int rd, int rs1);           return mk(1, 1, 1, rd, rs1, 0);   endfunction
    function automatic instr_t sw(int rs1, int rs2);          return mk(0, 0, 1, 0, rs1, rs2);  endfunction
    function automatic instr_t nop();                         return mk(0, 0, 0, 0, 0, 0);      endfunction

    function automatic instr_t bubble();
        instr_t i;
        i = nop();
        i.valid = 1'b0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int k = $urandom_range(0, 9);
        int a = $urandom_range(0, 4);
        int b = $urandom_range(0, 4);
        int c = $urandom_range(0, 4);
        if (k <= 4) return alu(a, b, c);
        if (k <= 6) return lw(a, b);
        if (k == 7) return sw(b, c);
        return mk(0, 0, 0, 0, b, c);   // branch-like: reads, writes nothing
    endfunction

    function automatic bit writes(instr_t i, logic [4:0] r);
        return i.valid && i.wr && (i.rd == r) && (r != 5'd0);
    endfunction

    // Source comes from the nearest older instruction that writes it: M before W.
    function automatic logic [1:0] fwd_of(logic [4:0] rs);
        for (int k = 1; k <= 2; k++)
            if (writes(pipe[k], rs)) return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        pipe.delete();
        repeat (3) pipe.push_back(bubble());
        cnt_stall = 0;
        cnt_flush = 0;
        cnt_wait  = 0;
    endtask

    task automatic drive(input instr_t d, input bit pc, input bit mr);
        hz.rs1_d        = d.rs1;
        hz.rs2_d        = d.rs2;
        hz.rd_d         = d.rd;
        hz.reg_write_d  = d.wr;
        hz.result_src_d = d.ld;
        hz.mem_access_d = d.mem;
        hz.pc_src_e     = pc;
        hz.mem_ready    = mr;
    endtask

    // One pipeline cycle out of reset: drive D, predict the outputs, then advance the model.
    task automatic cyc(input instr_t d, input bit pc, input bit mr, output exp_t e);
        bit wait_m, redir, lu;
        @(negedge clk);
        rst_n = 1'b1;
        drive(d, pc, mr);
        wait_m = pipe[1].valid && pipe[1].mem && !mr;
        redir  = pc && !wait_m;
        lu     = !wait_m && !pc && pipe[0].ld &&
                 (writes(pipe[0], d.rs1) || writes(pipe[0], d.rs2));
        e.ctl  = {wait_m || lu, wait_m || lu, redir, redir || lu, wait_m};
        e.fwd  = {fwd_of(pipe[0].rs1), fwd_of(pipe[0].rs2)};
        e.perf = PERF_EN ? {cnt_stall, cnt_flush, cnt_wait} : 96'd0;
        exp_q.push_back(e);
        if (lu)     cnt_stall++;
        if (redir)  cnt_flush++;
        if (wait_m) cnt_wait++;
        if (!wait_m) begin
            void'(pipe.pop_back());
            pipe.push_front((redir || lu) ? bubble() : d);
        end
    endtask

    // One cycle held in reset with random inputs: everything must read zero.
    task automatic reset_cyc();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        drive(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        e.ctl  = '0;
        e.fwd  = '0;
        e.perf = '0;
        exp_q.push_back(e);
        model_clear();
    endtask

    task automatic step(input instr_t d);
        exp_t e;
        cyc(d, 1'b0, 1'b1, e);
    endtask

    task automatic stepx(input instr_t d, input bit pc, input bit mr);
        exp_t e;
        cyc(d, pc, mr, e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ctl(stall_f,stall_d,flush_d,flush_e,freeze)",
                      {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e, hz.freeze}, e.ctl);
                check("fwd(a,b)", {hz.fwd_a_sel, hz.fwd_b_sel}, e.fwd);
                check("perf(stall,flush,wait)",
                      {hz.perf_stall_cnt, hz.perf_flush_cnt, hz.perf_wait_cnt}, e.perf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within 500000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t   e;
        instr_t cur;
        bit     pc, mr;

        drive(nop(), 1'b0, 1'b1);
        model_clear();
        reset_cyc();
        reset_cyc();

        // Back-to-back ALU: M producer forwards (10).
        step(alu(5, 1, 2)); step(alu(6, 5, 3)); step(nop()); step(nop()); step(nop());
        // Same rd in W and M: M wins (10).
        step(alu(5, 1, 2)); step(alu(5, 3, 4)); step(alu(9, 5, 5)); step(nop()); step(nop()); step(nop());
        // Producer only in W (01).
        step(alu(5, 1, 2)); step(nop()); step(alu(9, 5, 0)); step(nop()); step(nop()); step(nop());
        // rd = x0 in M never forwards (00).
        step(alu(0, 1, 1)); step(alu(9, 0, 0)); step(nop()); step(nop()); step(nop());

        // Load-use: one bubble, then the consumer forwards from W.
        step(lw(7, 1)); step(alu(8, 1, 7)); step(alu(8, 1, 7)); step(nop()); step(nop()); step(nop());

        // Redirect together with a load-use: flushes win, no stall.
        step(lw(7, 1)); stepx(alu(8, 7, 2), 1'b1, 1'b1); step(nop()); step(nop()); step(nop());

        // Store in M with memory not ready for three cycles.
        step(sw(1, 2)); step(nop());
        stepx(nop(), 1'b0, 1'b0); stepx(nop(), 1'b0, 1'b0); stepx(nop(), 1'b0, 1'b0);
        step(nop()); step(nop()); step(nop());

        // Redirect raised during a freeze takes effect on the first unfrozen cycle.
        step(sw(1, 2)); step(alu(4, 1, 1));
        stepx(nop(), 1'b1, 1'b0); stepx(nop(), 1'b1, 1'b0); stepx(nop(), 1'b1, 1'b1);
        step(nop()); step(nop()); step(nop());

        // Asynchronous reset in the middle of a memory wait.
        step(alu(5, 1, 1)); step(sw(3, 4)); step(alu(6, 5, 5));
        stepx(alu(7, 5, 6), 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e, hz.freeze,
               hz.fwd_a_sel, hz.fwd_b_sel,
               hz.perf_stall_cnt, hz.perf_flush_cnt, hz.perf_wait_cnt}, '0);
        reset_cyc();
        reset_cyc();
        // Restart from an empty scoreboard: no forwarding until new writers arrive.
        step(alu(9, 5, 6)); step(nop()); step(alu(3, 9, 9)); step(nop()); step(nop());

        // Random traffic with a pipeline-like front end honouring stall and flush.
        cur = rand_instr();
        for (int n = 0; n < 3000; n++) begin
            pc = ($urandom_range(0, 7) == 0);
            mr = ($urandom_range(0, 3) != 0);
            cyc(cur, pc, mr, e);
            if (!e.ctl[3]) cur = e.ctl[2] ? nop() : rand_instr();
        end

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
